// File: rtl/ladder_counter_gen.sv
// Bounded position counter: steps by a programmable delta, with wrap, saturate or bounce at the limits.
// Latency: current/count/dir_out/wrapped are registered, one cycle after inputs are sampled.
// Backpressure: none; en is sampled every cycle, and a load or a config error takes precedence over en.
module ladder_counter_gen #(
    parameter int WIDTH   = 4,
    parameter int DELTA_W = 3,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_value,
    input  logic [DELTA_W-1:0] delta,
    input  logic               direction,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   lo_limit,
    input  logic [WIDTH-1:0]   hi_limit,
    output logic [WIDTH-1:0]   current,
    output logic [CNT_W-1:0]   count,
    output logic               dir_out,
    output logic               at_top,
    output logic               at_bottom,
    output logic               wrapped,
    output logic               cfg_err
);

    // Two guard bits keep current +/- delta and the reflection terms free of overflow.
    localparam int SW = ((WIDTH > DELTA_W) ? WIDTH : DELTA_W) + 2;
    typedef logic signed [SW-1:0] sval_t;
    localparam sval_t S_ONE = sval_t'(1);

    sval_t s_cur, s_lo, s_hi, s_d, s_span, s_n, s_r;
    logic  bounce_m, wrap_m, eff_up;

    logic [WIDTH-1:0] nxt_cur;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_dir;
    logic             nxt_wrap;

    assign s_cur  = {{(SW-WIDTH){1'b0}}, current};
    assign s_lo   = {{(SW-WIDTH){1'b0}}, lo_limit};
    assign s_hi   = {{(SW-WIDTH){1'b0}}, hi_limit};
    assign s_d    = {{(SW-DELTA_W){1'b0}}, delta};
    assign s_span = s_hi - s_lo + S_ONE;

    assign cfg_err   = (lo_limit > hi_limit);
    assign at_top    = (current == hi_limit);
    assign at_bottom = (current == lo_limit);

    // Mode 11 falls through to saturate.
    assign wrap_m   = (mode == 2'b00);
    assign bounce_m = (mode == 2'b10);
    assign eff_up   = bounce_m ? dir_out : direction;
    assign s_n      = eff_up ? (s_cur + s_d) : (s_cur - s_d);

    always_comb begin
        nxt_cur  = current;
        nxt_cnt  = count;
        nxt_dir  = dir_out;
        nxt_wrap = 1'b0;
        s_r      = s_n;
        if (cfg_err) begin
            nxt_cur = current;
        end else if (load) begin
            if (load_value < lo_limit)
                nxt_cur = lo_limit;
            else if (load_value > hi_limit)
                nxt_cur = hi_limit;
            else
                nxt_cur = load_value;
            nxt_cnt = '0;
            nxt_dir = direction;
        end else if (en && (delta != '0)) begin
            nxt_cnt = count + CNT_W'(1);
            if ((current < lo_limit) || (current > hi_limit)) begin
                nxt_cur = lo_limit;
                nxt_dir = 1'b1;
            end else begin
                if (!bounce_m)
                    nxt_dir = direction;
                if (lo_limit == hi_limit) begin
                    nxt_cur = lo_limit;
                end else if ((s_n >= s_lo) && (s_n <= s_hi)) begin
                    nxt_cur = s_n[WIDTH-1:0];
                end else if (wrap_m) begin
                    s_r      = (s_n > s_hi) ? (s_n - s_span) : (s_n + s_span);
                    nxt_wrap = 1'b1;
                    if ((s_r >= s_lo) && (s_r <= s_hi))
                        nxt_cur = s_r[WIDTH-1:0];
                    else
                        nxt_cur = lo_limit;
                end else if (bounce_m) begin
                    // Reflect around the crossed limit, grouped so no term exceeds hi + delta.
                    if (s_n > s_hi) begin
                        s_r     = s_hi - (s_n - s_hi);
                        nxt_dir = 1'b0;
                    end else begin
                        s_r     = s_lo + (s_lo - s_n);
                        nxt_dir = 1'b1;
                    end
                    nxt_wrap = 1'b1;
                    if (s_r < s_lo)
                        nxt_cur = lo_limit;
                    else if (s_r > s_hi)
                        nxt_cur = hi_limit;
                    else
                        nxt_cur = s_r[WIDTH-1:0];
                end else begin
                    nxt_cur = (s_n > s_hi) ? hi_limit : lo_limit;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current <= '0;
            count   <= '0;
            dir_out <= 1'b1;
            wrapped <= 1'b0;
        end else begin
            current <= nxt_cur;
            count   <= nxt_cnt;
            dir_out <= nxt_dir;
            wrapped <= nxt_wrap;
        end
    end

endmodule

// File: tb/tb_ladder_counter_gen.sv
// Bench for ladder_counter_gen: directed scenarios plus random traffic against an integer reference model.
module tb_ladder_counter_gen;

    localparam int WIDTH   = 4;
    localparam int DELTA_W = 3;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               en = 1'b0;
    logic               load = 1'b0;
    logic [WIDTH-1:0]   load_value = '0;
    logic [DELTA_W-1:0] delta = '0;
    logic               direction = 1'b1;
    logic [1:0]         mode = 2'b00;
    logic [WIDTH-1:0]   lo_limit = '0;
    logic [WIDTH-1:0]   hi_limit = '1;
    logic [WIDTH-1:0]   current;
    logic [CNT_W-1:0]   count;
    logic               dir_out, at_top, at_bottom, wrapped, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int m_cur, m_cnt, m_dir, m_wrap;

    ladder_counter_gen #(.WIDTH(WIDTH), .DELTA_W(DELTA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_value(load_value),
        .delta(delta), .direction(direction), .mode(mode), .lo_limit(lo_limit),
        .hi_limit(hi_limit), .current(current), .count(count), .dir_out(dir_out),
        .at_top(at_top), .at_bottom(at_bottom), .wrapped(wrapped), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_cnt = 0; m_dir = 1; m_wrap = 0;
    endtask

    // Next state from the behavioural rules, evaluated on the inputs present before the edge.
    task automatic model_step();
        int lo, hi, cur, d, n, r, span;
        bit up;
        lo = int'(lo_limit); hi = int'(hi_limit); cur = m_cur; d = int'(delta);
        span = hi - lo + 1;
        m_wrap = 0;
        if (lo > hi) return;
        if (load) begin
            m_cur = (int'(load_value) < lo) ? lo : (int'(load_value) > hi) ? hi : int'(load_value);
            m_cnt = 0;
            m_dir = int'(direction);
            return;
        end
        if (!en || d == 0) return;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (cur < lo || cur > hi) begin
            m_cur = lo; m_dir = 1;
            return;
        end
        if (mode == 2'b10) up = (m_dir != 0);
        else begin up = direction; m_dir = int'(direction); end
        if (lo == hi) begin m_cur = lo; return; end
        n = up ? cur + d : cur - d;
        if (n >= lo && n <= hi) begin m_cur = n; return; end
        case (mode)
            2'b00: begin
                r = (n > hi) ? n - span : n + span;
                m_wrap = 1;
                m_cur = (r >= lo && r <= hi) ? r : lo;
            end
            2'b10: begin
                if (n > hi) begin r = 2 * hi - n; m_dir = 0; end
                else begin r = 2 * lo - n; m_dir = 1; end
                m_wrap = 1;
                m_cur = (r < lo) ? lo : (r > hi) ? hi : r;
            end
            default: m_cur = (n > hi) ? hi : lo;
        endcase
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".current"}, 32'(current), 32'(m_cur));
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
        chk({tag, ".dir_out"}, 32'(dir_out), 32'(m_dir));
        chk({tag, ".wrapped"}, 32'(wrapped), 32'(m_wrap));
        chk({tag, ".at_top"}, 32'(at_top), 32'(m_cur == int'(hi_limit)));
        chk({tag, ".at_bottom"}, 32'(at_bottom), 32'(m_cur == int'(lo_limit)));
        chk({tag, ".cfg_err"}, 32'(cfg_err), 32'(int'(lo_limit) > int'(hi_limit)));
    endtask

    // One clock: advance the model, take the edge, sample 1 ns later.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int exp_wrap_cur[6]  = '{3, 6, 9, 12, 15, 2};
    int exp_wrap_w[6]    = '{0, 0, 0, 0, 0, 1};
    int exp_sat_cur[3]   = '{1, 0, 0};
    int exp_bnc_cur[6]   = '{5, 8, 9, 6, 3, 4};
    int exp_bnc_dir[6]   = '{1, 1, 0, 0, 0, 1};
    int exp_bnc_w[6]     = '{0, 0, 1, 0, 0, 1};

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Wrap up across the top limit
        lo_limit = 4'd0; hi_limit = 4'd15; mode = 2'b00; direction = 1'b1; delta = 3'd3; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle("wrap");
            chk("wrap.cur_const", 32'(current), 32'(exp_wrap_cur[i]));
            chk("wrap.w_const", 32'(wrapped), 32'(exp_wrap_w[i]));
        end
        chk("wrap.count6", 32'(count), 32'd6);

        // Saturate down to the bottom
        en = 1'b0; load = 1'b1; load_value = 4'd3; direction = 1'b0; mode = 2'b01;
        cycle("sat_load");
        load = 1'b0; en = 1'b1; delta = 3'd2;
        for (int i = 0; i < 3; i++) begin
            cycle("sat");
            chk("sat.cur_const", 32'(current), 32'(exp_sat_cur[i]));
            chk("sat.cnt_const", 32'(count), 32'(i + 1));
            chk("sat.bottom_const", 32'(at_bottom), 32'(i >= 1));
        end

        // Bounce between 2 and 10; direction input is ignored after the load
        en = 1'b0; lo_limit = 4'd2; hi_limit = 4'd10; mode = 2'b10;
        load = 1'b1; load_value = 4'd2; direction = 1'b1;
        cycle("bnc_load");
        load = 1'b0; en = 1'b1; delta = 3'd3; direction = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle("bnc");
            chk("bnc.cur_const", 32'(current), 32'(exp_bnc_cur[i]));
            chk("bnc.dir_const", 32'(dir_out), 32'(exp_bnc_dir[i]));
            chk("bnc.w_const", 32'(wrapped), 32'(exp_bnc_w[i]));
        end

        // Load wins over en and clamps; delta==0 is a no-op
        lo_limit = 4'd0; hi_limit = 4'd10; mode = 2'b00; direction = 1'b1;
        load = 1'b1; en = 1'b1; load_value = 4'd12;
        cycle("prio");
        chk("prio.cur_const", 32'(current), 32'd10);
        chk("prio.cnt_const", 32'(count), 32'd0);
        load = 1'b0; delta = 3'd0;
        for (int i = 0; i < 3; i++) cycle("noop");
        chk("noop.cur_const", 32'(current), 32'd10);
        chk("noop.cnt_const", 32'(count), 32'd0);

        // Inverted limits freeze the counter
        lo_limit = 4'd9; hi_limit = 4'd4; delta = 3'd1; en = 1'b1;
        #1;
        chk("cfg.err_const", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 3; i++) cycle("cfg");
        chk("cfg.cur_const", 32'(current), 32'd10);

        // Limits tightened below current: next step snaps to lo
        lo_limit = 4'd0; hi_limit = 4'd15; load = 1'b1; load_value = 4'd12;
        cycle("rt_load");
        load = 1'b0; hi_limit = 4'd7;
        cycle("rt");
        chk("rt.cur_const", 32'(current), 32'd0);
        chk("rt.cnt_const", 32'(count), 32'd1);

        // Asynchronous reset between edges
        hi_limit = 4'd15; delta = 3'd3; load = 1'b1; load_value = 4'd6;
        cycle("ar_load");
        load = 1'b0;
        cycle("ar_step");
        chk("ar.cur9_const", 32'(current), 32'd9);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_all("ar_imm");
        chk("ar.cur0_const", 32'(current), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle("ar_resume");
        chk("ar.resume_const", 32'(current), 32'd3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            en         = ($urandom_range(0, 9) < 8);
            load       = ($urandom_range(0, 9) == 0);
            load_value = WIDTH'($urandom);
            delta      = DELTA_W'($urandom);
            direction  = 1'($urandom);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                lo_limit = WIDTH'($urandom);
                hi_limit = WIDTH'($urandom);
                if ($urandom_range(0, 9) != 0 && lo_limit > hi_limit) begin
                    logic [WIDTH-1:0] t;
                    t = lo_limit; lo_limit = hi_limit; hi_limit = t;
                end
            end
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
